wb2sci_multilayer_bridge: RTL and testbench



---
 rtl/wb2sci_multilayer_bridge_if.sv | 43 ++++
 rtl/wb2sci_multilayer_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_wb2sci_multilayer_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb2sci_multilayer_bridge_if.sv
// Bus bundle for the Wishbone-to-SCI bridge: Wishbone slave port plus the
// fan-out towards the per-layer SCI master engines.
interface wb2sci_multilayer_bridge_if #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_LAYERS        = 4,
  parameter int NEURONS_PER_LAYER = 16,
  parameter int REG_ADDR_WIDTH    = 5
);
  logic                                    WB_CYC;
  logic                                    WB_STB;
  logic                                    WB_WE;
  logic [ADDR_WIDTH-1:0]                   WB_ADDR;
  logic [DATA_WIDTH-1:0]                   WB_WDATA;
  logic [DATA_WIDTH/8-1:0]                 WB_SEL;
  logic                                    WB_STALL;
  logic                                    WB_ACK;
  logic [DATA_WIDTH-1:0]                   WB_RDATA;
  logic                                    WB_ERR;
  logic [NUM_LAYERS-1:0]                   M_REQ;
  logic                                    M_WNR;
  logic [REG_ADDR_WIDTH-1:0]               M_ADDR;
  logic [NUM_LAYERS*NEURONS_PER_LAYER-1:0] M_CSN;
  logic [DATA_WIDTH-1:0]                   M_DATA_IN;
  logic [NUM_LAYERS-1:0]                   M_ABORT;
  logic [NUM_LAYERS-1:0]                   M_ACK;
  logic [NUM_LAYERS*DATA_WIDTH-1:0]        M_DATA_OUT;
  logic [1:0]                              ERR_CODE;

  // Bridge side
  modport slave (
    input  WB_CYC, WB_STB, WB_WE, WB_ADDR, WB_WDATA, WB_SEL, M_ACK, M_DATA_OUT,
    output WB_STALL, WB_ACK, WB_RDATA, WB_ERR, M_REQ, M_WNR, M_ADDR, M_CSN,
           M_DATA_IN, M_ABORT, ERR_CODE
  );

  // Environment side: Wishbone host and SCI master engines
  modport master (
    output WB_CYC, WB_STB, WB_WE, WB_ADDR, WB_WDATA, WB_SEL, M_ACK, M_DATA_OUT,
    input  WB_STALL, WB_ACK, WB_RDATA, WB_ERR, M_REQ, M_WNR, M_ADDR, M_CSN,
           M_DATA_IN, M_ABORT, ERR_CODE
  );
endinterface

// File: rtl/wb2sci_multilayer_bridge.sv
// Wishbone B4 pipelined slave that turns single-word accesses into register
// transactions on one of NUM_LAYERS SCI masters, with broadcast writes and a response watchdog.
module wb2sci_multilayer_bridge #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_LAYERS        = 4,
  parameter int LAYER_SEL_WIDTH   = 2,
  parameter int NEURON_SEL_WIDTH  = 7,
  parameter int REG_SEL_WIDTH     = 8,
  parameter int NEURONS_PER_LAYER = 16,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                       CLK,
  input  logic                       RST,
  wb2sci_multilayer_bridge_if.slave  bus
);
  localparam int N       = NEURONS_PER_LAYER;
  localparam int CSN_W   = NUM_LAYERS * N;
  localparam int WDOG_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int REG_LSB = 2;
  localparam int NRN_LSB = REG_LSB + REG_SEL_WIDTH;
  localparam int LYR_LSB = NRN_LSB + NEURON_SEL_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERROR} state_t;

  state_t                      r_state, w_state_next;
  logic [WDOG_W-1:0]           r_wdog, w_wdog_next;
  logic [LAYER_SEL_WIDTH-1:0]  r_layer, w_layer_next;
  logic                        r_wb_ack, w_wb_ack_next;
  logic                        r_wb_err, w_wb_err_next;
  logic [DATA_WIDTH-1:0]       r_rdata, w_rdata_next;
  logic [NUM_LAYERS-1:0]       r_req, w_req_next;
  logic [NUM_LAYERS-1:0]       r_abort, w_abort_next;
  logic                        r_wnr, w_wnr_next;
  logic [REG_ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [CSN_W-1:0]            r_csn, w_csn_next;
  logic [DATA_WIDTH-1:0]       r_din, w_din_next;
  logic [1:0]                  r_err_code, w_err_code_next;

  logic [ADDR_WIDTH-1:0]       w_addr;
  logic [REG_SEL_WIDTH-1:0]    w_reg;
  logic [NEURON_SEL_WIDTH-1:0] w_neuron;
  logic [LAYER_SEL_WIDTH-1:0]  w_layer;
  logic                        w_bcast;
  logic                        w_accept;
  logic                        w_decode_err;
  logic                        w_unused_addr;
  logic [N-1:0]                w_nrn_mask;
  logic [NUM_LAYERS-1:0]       w_new_oh;
  logic [NUM_LAYERS-1:0]       w_cur_oh;
  logic [CSN_W-1:0]            w_csn_acc;
  logic [DATA_WIDTH-1:0]       w_rd_slice [NUM_LAYERS];
  logic [DATA_WIDTH-1:0]       w_rd_sel;
  logic                        w_m_ack_sel;

  // Word address fields from LSB upward: reg, neuron, layer; byte offset and top bits ignored
  assign w_addr        = bus.WB_ADDR;
  assign w_reg         = w_addr[REG_LSB +: REG_SEL_WIDTH];
  assign w_neuron      = w_addr[NRN_LSB +: NEURON_SEL_WIDTH];
  assign w_layer       = w_addr[LYR_LSB +: LAYER_SEL_WIDTH];
  assign w_unused_addr = ^w_addr;
  assign w_bcast       = &w_neuron;

  assign w_accept = (r_state == ST_IDLE) && bus.WB_CYC && bus.WB_STB && !r_wb_ack && !r_wb_err;

  assign w_decode_err = (32'(w_layer) >= NUM_LAYERS)
                     || (32'(w_reg) >= (32'd1 << REG_ADDR_WIDTH))
                     || ((32'(w_neuron) >= N) && !w_bcast)
                     || (bus.WB_WE && !(&bus.WB_SEL));

  // Active-low selects within the addressed layer; all-ones neuron selects the whole layer
  always_comb begin
    w_nrn_mask = '1;
    for (int n = 0; n < N; n++) begin
      w_nrn_mask[n] = !(w_bcast || (32'(w_neuron) == n));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      assign w_new_oh[gi]          = (32'(w_layer) == gi);
      assign w_cur_oh[gi]          = (32'(r_layer) == gi);
      assign w_csn_acc[gi*N +: N]  = w_new_oh[gi] ? w_nrn_mask : {N{1'b1}};
      assign w_rd_slice[gi]        = bus.M_DATA_OUT[gi*DATA_WIDTH +: DATA_WIDTH]
                                   & {DATA_WIDTH{w_cur_oh[gi]}};
    end
  endgenerate

  always_comb begin
    w_rd_sel = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      w_rd_sel = w_rd_sel | w_rd_slice[l];
    end
  end

  assign w_m_ack_sel = |(bus.M_ACK & w_cur_oh);

  always_comb begin
    w_state_next    = r_state;
    w_wdog_next     = r_wdog;
    w_layer_next    = r_layer;
    w_wb_ack_next   = 1'b0;
    w_wb_err_next   = 1'b0;
    w_rdata_next    = r_rdata;
    w_req_next      = '0;
    w_abort_next    = '0;
    w_wnr_next      = r_wnr;
    w_addr_next     = r_addr;
    w_csn_next      = r_csn;
    w_din_next      = r_din;
    w_err_code_next = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_layer_next    = w_layer;
          w_wnr_next      = bus.WB_WE;
          w_addr_next     = w_reg[REG_ADDR_WIDTH-1:0];
          w_din_next      = bus.WB_WDATA;
          w_wdog_next     = '0;
          w_err_code_next = 2'd0;
          if (w_decode_err) begin
            w_state_next    = ST_ERROR;
            w_wb_err_next   = 1'b1;
            w_err_code_next = 2'd1;
          end else if (w_bcast && !bus.WB_WE) begin
            w_state_next    = ST_ERROR;
            w_wb_err_next   = 1'b1;
            w_err_code_next = 2'd3;
          end else begin
            w_state_next = ST_WAIT;
            w_req_next   = w_new_oh;
            w_csn_next   = w_csn_acc;
          end
        end
      end
      ST_WAIT: begin
        // An ack in the expiry cycle still completes the access normally
        if (w_m_ack_sel) begin
          w_state_next  = ST_IDLE;
          w_wb_ack_next = 1'b1;
          w_csn_next    = '1;
          if (!r_wnr) begin
            w_rdata_next = w_rd_sel;
          end
        end else if (r_wdog == WDOG_W'(TIMEOUT_CYCLES)) begin
          w_state_next    = ST_IDLE;
          w_wb_err_next   = 1'b1;
          w_err_code_next = 2'd2;
          w_abort_next    = w_cur_oh;
          w_csn_next      = '1;
        end else begin
          w_wdog_next = r_wdog + WDOG_W'(1);
        end
      end
      ST_ERROR: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_wdog     <= '0;
      r_layer    <= '0;
      r_wb_ack   <= 1'b0;
      r_wb_err   <= 1'b0;
      r_rdata    <= '0;
      r_req      <= '0;
      r_abort    <= '0;
      r_wnr      <= 1'b0;
      r_addr     <= '0;
      r_csn      <= '1;
      r_din      <= '0;
      r_err_code <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_wdog     <= w_wdog_next;
      r_layer    <= w_layer_next;
      r_wb_ack   <= w_wb_ack_next;
      r_wb_err   <= w_wb_err_next;
      r_rdata    <= w_rdata_next;
      r_req      <= w_req_next;
      r_abort    <= w_abort_next;
      r_wnr      <= w_wnr_next;
      r_addr     <= w_addr_next;
      r_csn      <= w_csn_next;
      r_din      <= w_din_next;
      r_err_code <= w_err_code_next;
    end
  end

  assign bus.WB_STALL  = (r_state != ST_IDLE) | r_wb_ack | r_wb_err;
  assign bus.WB_ACK    = r_wb_ack;
  assign bus.WB_ERR    = r_wb_err;
  assign bus.WB_RDATA  = r_rdata;
  assign bus.M_REQ     = r_req;
  assign bus.M_ABORT   = r_abort;
  assign bus.M_WNR     = r_wnr;
  assign bus.M_ADDR    = r_addr;
  assign bus.M_CSN     = r_csn;
  assign bus.M_DATA_IN = r_din;
  assign bus.ERR_CODE  = r_err_code;
endmodule

// File: tb/tb_wb2sci_multilayer_bridge.sv
// Randomised scoreboard bench for wb2sci_multilayer_bridge: the driver predicts each
// access from the address-map rules, a negedge monitor compares what the bridge presents.
module tb_wb2sci_multilayer_bridge;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NL    = 4;
  localparam int LSW   = 2;
  localparam int NSW   = 7;
  localparam int RSW   = 8;
  localparam int NPL   = 16;
  localparam int RAW   = 5;
  localparam int TO    = 8;
  localparam int CSN_W = NL * NPL;
  localparam int NMAX  = (1 << NSW) - 1;

  typedef struct {
    logic [NL-1:0]    req;
    logic [CSN_W-1:0] csn;
    logic [RAW-1:0]   addr;
    logic             wnr;
    logic [DW-1:0]    din;
    int               cyc;
  } req_exp_t;

  typedef struct {
    logic          err;
    logic [1:0]    code;
    logic [DW-1:0] rdata;
    logic [NL-1:0] abort;
    int            cyc;
  } rsp_exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  logic [DW-1:0] last_rdata = '0;
  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  wb2sci_multilayer_bridge_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LAYERS(NL),
    .NEURONS_PER_LAYER(NPL), .REG_ADDR_WIDTH(RAW)
  ) bif ();

  wb2sci_multilayer_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LAYERS(NL), .LAYER_SEL_WIDTH(LSW),
    .NEURON_SEL_WIDTH(NSW), .REG_SEL_WIDTH(RSW), .NEURONS_PER_LAYER(NPL),
    .REG_ADDR_WIDTH(RAW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bif)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] mkaddr(input int lyr, input int nrn, input int rg);
    return AW'(((lyr * (1 << NSW) + nrn) * (1 << RSW) + rg) * 4);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_stall"},   64'(bif.WB_STALL),  64'd0);
    check({tag, "_ack"},     64'(bif.WB_ACK),    64'd0);
    check({tag, "_err"},     64'(bif.WB_ERR),    64'd0);
    check({tag, "_rdata"},   64'(bif.WB_RDATA),  64'd0);
    check({tag, "_m_req"},   64'(bif.M_REQ),     64'd0);
    check({tag, "_m_abort"}, 64'(bif.M_ABORT),   64'd0);
    check({tag, "_m_wnr"},   64'(bif.M_WNR),     64'd0);
    check({tag, "_m_addr"},  64'(bif.M_ADDR),    64'd0);
    check({tag, "_m_din"},   64'(bif.M_DATA_IN), 64'd0);
    check({tag, "_m_csn"},   64'(bif.M_CSN),     64'({CSN_W{1'b1}}));
    check({tag, "_errcode"}, 64'(bif.ERR_CODE),  64'd0);
  endtask

  // Predict one access from the address map, then play host and SCI master for it
  task automatic issue(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                       input logic [3:0] sel, input int delay, input logic [DW-1:0] rdval,
                       input bit keep_cyc, input bit spur, input bit rst_mid);
    int word, rg, nrn, lyr, guard, acc;
    bit dec_err, bcast, bcast_rd;
    req_exp_t rq;
    rsp_exp_t rs;
    logic [CSN_W-1:0] csn;
    guard = 0;
    while (bif.WB_STALL !== 1'b0 && guard < 64) begin
      @(negedge CLK);
      guard++;
    end
    if (bif.WB_STALL !== 1'b0) begin
      check("bus_idle_wait", 64'(bif.WB_STALL), 64'd0);
      return;
    end
    word = int'(addr >> 2);
    rg   = word % (1 << RSW);
    nrn  = (word / (1 << RSW)) % (1 << NSW);
    lyr  = (word / (1 << (RSW + NSW))) % (1 << LSW);
    bcast    = (nrn == NMAX);
    dec_err  = (lyr >= NL) || (rg >= (1 << RAW)) || (nrn >= NPL && !bcast) || (we && sel != 4'hF);
    bcast_rd = !dec_err && bcast && !we;
    acc = cyc;
    rs.abort = '0;
    rs.rdata = last_rdata;
    if (dec_err || bcast_rd) begin
      rs.err  = 1'b1;
      rs.code = dec_err ? 2'd1 : 2'd3;
      rs.cyc  = acc + 1;
    end else begin
      csn = '1;
      for (int n = 0; n < NPL; n++) begin
        if (bcast || n == nrn) csn[lyr*NPL + n] = 1'b0;
      end
      rq.req  = NL'(1) << lyr;
      rq.csn  = csn;
      rq.addr = RAW'(rg);
      rq.wnr  = we;
      rq.din  = wdata;
      rq.cyc  = acc + 1;
      req_q.push_back(rq);
      if (delay <= TO) begin
        rs.err  = 1'b0;
        rs.code = 2'd0;
        rs.cyc  = acc + delay + 2;
        if (!we) rs.rdata = rdval;
      end else begin
        rs.err   = 1'b1;
        rs.code  = 2'd2;
        rs.abort = NL'(1) << lyr;
        rs.cyc   = acc + TO + 2;
      end
    end
    if (!rst_mid) begin
      rsp_q.push_back(rs);
      last_rdata = rs.rdata;
    end
    for (int l = 0; l < NL; l++) bif.M_DATA_OUT[l*DW +: DW] = $urandom;
    bif.M_DATA_OUT[lyr*DW +: DW] = rdval;
    bif.WB_CYC   = 1'b1;
    bif.WB_STB   = 1'b1;
    bif.WB_WE    = we;
    bif.WB_ADDR  = addr;
    bif.WB_WDATA = wdata;
    bif.WB_SEL   = sel;
    @(negedge CLK);
    bif.WB_STB   = 1'b0;
    bif.WB_CYC   = keep_cyc;
    bif.WB_ADDR  = $urandom;
    bif.WB_WDATA = $urandom;
    if (!(dec_err || bcast_rd)) begin
      if (rst_mid) begin
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset("rst_mid");
        RST = 1'b0;
        last_rdata = '0;
      end else begin
        for (int c = 0; c <= delay; c++) begin
          bif.M_ACK = '0;
          if (c == delay) bif.M_ACK[lyr] = 1'b1;
          else if (spur && c == 0) bif.M_ACK[(lyr + 1) % NL] = 1'b1;
          @(negedge CLK);
        end
        bif.M_ACK = '0;
      end
    end
    bif.WB_CYC = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the bridge presents a request or a termination
  always @(negedge CLK) begin
    if (bif.M_REQ != '0) begin
      if (req_q.size() == 0) begin
        check("unexpected_m_req", 64'(bif.M_REQ), 64'd0);
      end else begin
        req_exp_t e;
        e = req_q.pop_front();
        check("m_req",       64'(bif.M_REQ),     64'(e.req));
        check("m_csn",       64'(bif.M_CSN),     64'(e.csn));
        check("m_addr",      64'(bif.M_ADDR),    64'(e.addr));
        check("m_wnr",       64'(bif.M_WNR),     64'(e.wnr));
        check("m_din",       64'(bif.M_DATA_IN), 64'(e.din));
        check("m_req_cycle", 64'(cyc),           64'(e.cyc));
        check("m_req_stall", 64'(bif.WB_STALL),  64'd1);
      end
    end
    if (bif.WB_ACK || bif.WB_ERR) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_wb_resp", 64'({bif.WB_ACK, bif.WB_ERR}), 64'd0);
      end else begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        n_txn++;
        check("wb_ack",      64'(bif.WB_ACK),   64'(!e.err));
        check("wb_err",      64'(bif.WB_ERR),   64'(e.err));
        check("err_code",    64'(bif.ERR_CODE), 64'(e.code));
        check("wb_rdata",    64'(bif.WB_RDATA), 64'(e.rdata));
        check("m_abort",     64'(bif.M_ABORT),  64'(e.abort));
        check("csn_release", 64'(bif.M_CSN),    64'({CSN_W{1'b1}}));
        check("resp_stall",  64'(bif.WB_STALL), 64'd1);
        check("resp_cycle",  64'(cyc),          64'(e.cyc));
        $display("txn %0d: %s code=%0d rdata=%h cycle=%0d", n_txn,
                 bif.WB_ERR ? "err" : "ack", bif.ERR_CODE, bif.WB_RDATA, cyc);
      end
    end else if (bif.M_ABORT != '0) begin
      check("stray_abort", 64'(bif.M_ABORT), 64'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench still running at cycle %0d, expected completion", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    bif.WB_CYC     = 1'b0;
    bif.WB_STB     = 1'b0;
    bif.WB_WE      = 1'b0;
    bif.WB_ADDR    = '0;
    bif.WB_WDATA   = '0;
    bif.WB_SEL     = '0;
    bif.M_ACK      = '0;
    bif.M_DATA_OUT = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset("por");
    RST = 1'b0;
    @(negedge CLK);

    issue(32'h0000_0C14, 1'b1, 32'hDEADBEEF, 4'hF, 4, $urandom, 1'b1, 1'b0, 1'b0);
    issue(mkaddr(2, 0, 1), 1'b0, $urandom, 4'hF, 3, 32'h12345678, 1'b1, 1'b0, 1'b0);
    issue(mkaddr(1, NMAX, 2), 1'b1, 32'hA5A5_0001, 4'hF, 2, $urandom, 1'b1, 1'b0, 1'b0);
    issue(mkaddr(1, NMAX, 2), 1'b0, $urandom, 4'hF, 2, $urandom, 1'b1, 1'b0, 1'b0);
    issue(mkaddr(0, 20, 1), 1'b1, $urandom, 4'hF, 2, $urandom, 1'b1, 1'b0, 1'b0);
    issue(mkaddr(0, 3, 1), 1'b1, $urandom, 4'b0011, 2, $urandom, 1'b1, 1'b0, 1'b0);
    issue(mkaddr(3, 1, 40), 1'b0, $urandom, 4'hF, 2, $urandom, 1'b1, 1'b0, 1'b0);
    issue(mkaddr(3, 5, 7), 1'b1, $urandom, 4'hF, 11, $urandom, 1'b0, 1'b0, 1'b0);
    issue(mkaddr(2, 9, 4), 1'b0, $urandom, 4'hF, TO, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);
    issue(mkaddr(1, 15, 31), 1'b0, $urandom, 4'hF, TO + 1, $urandom, 1'b1, 1'b0, 1'b0);
    issue(mkaddr(1, 2, 3), 1'b1, $urandom, 4'hF, 20, $urandom, 1'b1, 1'b0, 1'b1);
    issue(mkaddr(1, 2, 3), 1'b0, $urandom, 4'hF, 1, 32'hCAFE_0042, 1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      int lyr, nrn, rg, dly;
      logic [AW-1:0] a;
      logic [3:0] sel;
      logic we;
      lyr = $urandom_range(0, NL - 1);
      case ($urandom_range(0, 9))
        0:       nrn = NMAX;
        1:       nrn = $urandom_range(NPL, NMAX - 1);
        default: nrn = $urandom_range(0, NPL - 1);
      endcase
      rg  = ($urandom_range(0, 9) == 0) ? $urandom_range(1 << RAW, (1 << RSW) - 1)
                                         : $urandom_range(0, (1 << RAW) - 1);
      a   = mkaddr(lyr, nrn, rg) | AW'($urandom_range(0, 3)) | ($urandom & 32'hFFF8_0000);
      we  = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      dly = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 6);
      issue(a, we, $urandom, sel, dly, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (20) @(negedge CLK);
    check("req_q_drained", 64'(req_q.size()), 64'd0);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
